ft_alu_retry_ctrl: RTL and testbench

Sequential transaction controller that sits directly upstream of the fault-tolerant 3-bit ALU (`main`) and consumes its results. It accepts one request over a valid/ready handshake and drives the ALU inputs from registers. After a settle window it samples the dual ALU results and their two-rail error pairs. It retries transient failures a bounded number of times, then returns a checked result or a fail flag over a second valid/ready handshake.

---
 rtl/ft_alu_retry_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_ft_alu_retry_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ft_alu_retry_ctrl.sv
// ft_alu_retry_ctrl: request/response controller in front of the fault-tolerant
// 3-bit ALU. Registers operands into the ALU, waits a settle window, samples the
// dual-rail results, retries transient faults a bounded number of times and
// returns a checked sum/carry or a fail flag.
// Optional feature macro: FT_ALU_INPUT_CHECK_EN (operand parity and one-hot
// control check at acceptance; failing requests respond immediately).
module ft_alu_retry_ctrl #(
  parameter int unsigned SETTLE    = 1,
  parameter int unsigned MAX_RETRY = 2,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_a,
  input  logic [2:0]       in_b,
  input  logic             in_par,
  input  logic [2:0]       in_ctl,
  output logic [2:0]       alu_a,
  output logic [2:0]       alu_b,
  output logic             alu_par,
  output logic [2:0]       alu_c,
  input  logic [2:0]       alu_x,
  input  logic [2:0]       alu_y,
  input  logic             alu_xc,
  input  logic             alu_yc,
  input  logic [1:0]       alu_xe,
  input  logic [1:0]       alu_ye,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_sum,
  output logic             out_carry,
  output logic             out_fail,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned SCNT_W = 4;
  localparam int unsigned RTRY_W = 3;
  localparam logic [SCNT_W-1:0] SETTLE_LD = SCNT_W'(SETTLE - 1);
  localparam logic [RTRY_W-1:0] RETRY_LIM = RTRY_W'(MAX_RETRY);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [SCNT_W-1:0] settle_q, settle_d;
  logic [RTRY_W-1:0] retry_q, retry_d;
  logic [2:0]        alu_a_d, alu_b_d, alu_c_d;
  logic              alu_par_d;
  logic              out_valid_d, out_carry_d, out_fail_d;
  logic [2:0]        out_sum_d;
  logic [CNT_W-1:0]  err_cnt_d;
  logic              err_inc;
  logic              sample_good;
  logic              req_ok;

  // Both rails must disagree on each error pair and both result copies must agree
  assign sample_good = (alu_xe[1] ^ alu_xe[0]) & (alu_ye[1] ^ alu_ye[0]) &
                       (alu_x == alu_y) & (alu_xc == alu_yc);

`ifdef FT_ALU_INPUT_CHECK_EN
  logic ctl_onehot;
  // Exactly one control bit set: non-zero and no two bits set together
  assign ctl_onehot = (in_ctl != 3'b000) && ((in_ctl & (in_ctl - 3'd1)) == 3'b000);
  assign req_ok     = (^{in_a, in_b, in_par}) & ctl_onehot;
`else
  assign req_ok     = 1'b1;
`endif

  // Accept only from IDLE, so a response handshake never overlaps a new accept
  assign in_ready = (state_q == S_IDLE);

  // Saturating bad-sample counter
  assign err_cnt_d = (err_inc && (err_cnt != {CNT_W{1'b1}})) ? err_cnt + CNT_W'(1) : err_cnt;

  // Next-state and datapath decode
  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    retry_d     = retry_q;
    alu_a_d     = alu_a;
    alu_b_d     = alu_b;
    alu_c_d     = alu_c;
    alu_par_d   = alu_par;
    out_valid_d = out_valid;
    out_sum_d   = out_sum;
    out_carry_d = out_carry;
    out_fail_d  = out_fail;
    err_inc     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          alu_a_d   = in_a;
          alu_b_d   = in_b;
          alu_c_d   = in_ctl;
          alu_par_d = in_par;
          settle_d  = SETTLE_LD;
          retry_d   = '0;
          if (req_ok) begin
            state_d = S_ISSUE;
          end else begin
            state_d     = S_RESP;
            out_valid_d = 1'b1;
            out_sum_d   = 3'd0;
            out_carry_d = 1'b0;
            out_fail_d  = 1'b1;
            err_inc     = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (settle_q != '0) begin
          settle_d = settle_q - SCNT_W'(1);
        end else if (sample_good) begin
          state_d     = S_RESP;
          out_valid_d = 1'b1;
          out_sum_d   = alu_x;
          out_carry_d = alu_xc;
          out_fail_d  = 1'b0;
        end else if (retry_q < RETRY_LIM) begin
          retry_d  = retry_q + RTRY_W'(1);
          settle_d = SETTLE_LD;
          err_inc  = 1'b1;
        end else begin
          state_d     = S_RESP;
          out_valid_d = 1'b1;
          out_sum_d   = 3'd0;
          out_carry_d = 1'b0;
          out_fail_d  = 1'b1;
          err_inc     = 1'b1;
        end
      end
      S_RESP: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      settle_q  <= '0;
      retry_q   <= '0;
      alu_a     <= 3'd0;
      alu_b     <= 3'd0;
      alu_c     <= 3'd0;
      alu_par   <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= 3'd0;
      out_carry <= 1'b0;
      out_fail  <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      retry_q   <= retry_d;
      alu_a     <= alu_a_d;
      alu_b     <= alu_b_d;
      alu_c     <= alu_c_d;
      alu_par   <= alu_par_d;
      out_valid <= out_valid_d;
      out_sum   <= out_sum_d;
      out_carry <= out_carry_d;
      out_fail  <= out_fail_d;
      err_cnt   <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_ft_alu_retry_ctrl.sv
// Testbench for ft_alu_retry_ctrl: table vectors, hand sequences and random
// transactions checked against a behavioural model of the retry rules.
`timescale 1ns/1ps
module tb_ft_alu_retry_ctrl;

  localparam int unsigned SETTLE    = 2;
  localparam int unsigned MAX_RETRY = 2;
  localparam int unsigned CNT_W     = 4;
  localparam int          CNT_MAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [2:0] in_a = '0, in_b = '0, in_ctl = '0;
  logic in_par = 1'b0;
  logic [2:0] alu_x = '0, alu_y = '0;
  logic alu_xc = 1'b0, alu_yc = 1'b0;
  logic [1:0] alu_xe = 2'b01, alu_ye = 2'b01;
  logic in_ready, alu_par, out_valid, out_carry, out_fail;
  logic [2:0] alu_a, alu_b, alu_c, out_sum;
  logic [CNT_W-1:0] err_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ft_alu_retry_ctrl #(.SETTLE(SETTLE), .MAX_RETRY(MAX_RETRY), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_par(in_par), .in_ctl(in_ctl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_par(alu_par), .alu_c(alu_c),
    .alu_x(alu_x), .alu_y(alu_y), .alu_xc(alu_xc), .alu_yc(alu_yc),
    .alu_xe(alu_xe), .alu_ye(alu_ye), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_carry(out_carry), .out_fail(out_fail), .err_cnt(err_cnt)
  );

  typedef struct {
    logic [2:0] a, b, ctl, sum;
    logic       carry;
    logic [2:0] bad;       // bit k set: ALU sample k is corrupted
    int         hold;      // cycles of out_ready backpressure
    logic [2:0] exp_sum;
    logic       exp_carry;
    logic       exp_fail;
    int         exp_lat;   // edges after accept until out_valid is seen
    int         exp_err;
  } vec_t;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic logic odd_par(input logic [2:0] a, input logic [2:0] b);
    return ~(^{a, b});
  endfunction

  // Present one ALU sample; corrupted samples rotate through three fault kinds
  task automatic drive_alu(input logic bad, input int kind, input logic [2:0] s, input logic c);
    alu_x = s; alu_y = s; alu_xc = c; alu_yc = c; alu_xe = 2'b01; alu_ye = 2'b10;
    if (bad) begin
      case (kind % 3)
        0: alu_x = s ^ 3'b001;
        1: alu_xe = 2'b11;
        default: alu_yc = ~c;
      endcase
    end
  endtask

  task automatic run_txn(input string tag, input vec_t v);
    logic [2:0] bad;
    logic       par;
    int         lat;
    int         idx;
    bad = v.bad;
    par = odd_par(v.a, v.b);
    chk({tag, " in_ready_idle"}, int'(in_ready), 1);
    in_a = v.a; in_b = v.b; in_ctl = v.ctl; in_par = par; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    drive_alu(bad[0], 0, v.sum, v.carry);
    lat = -1;
    for (int n = 1; n <= int'(SETTLE * (MAX_RETRY + 1)) + 6; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = n;
        break;
      end
      idx = n / int'(SETTLE);
      if (idx > 2) idx = 2;
      drive_alu(bad[idx], idx, v.sum, v.carry);
    end
    chk({tag, " latency"}, lat, v.exp_lat);
    if (lat < 0) return;
    chk({tag, " out_sum"}, int'(out_sum), int'(v.exp_sum));
    chk({tag, " out_carry"}, int'(out_carry), int'(v.exp_carry));
    chk({tag, " out_fail"}, int'(out_fail), int'(v.exp_fail));
    chk({tag, " err_cnt"}, int'(err_cnt), v.exp_err);
    chk({tag, " alu_ops"}, int'({alu_a, alu_b, alu_c, alu_par}), int'({v.a, v.b, v.ctl, par}));
    // Backpressure: response holds, new requests are ignored
    for (int h = 0; h < v.hold; h++) begin
      in_valid = 1'b1; in_a = ~v.a; in_ctl = 3'b001;
      @(posedge clk); #1;
      chk({tag, " bp_hold"}, int'({out_valid, in_ready, out_sum, out_carry, out_fail}),
          int'({1'b1, 1'b0, v.exp_sum, v.exp_carry, v.exp_fail}));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " back_to_idle"}, int'({in_ready, out_valid}), 2'b10);
  endtask

  function automatic vec_t mk(input logic [2:0] a, b, ctl, sum, input logic carry,
                              input logic [2:0] bad, input int hold,
                              input logic [2:0] es, input logic ec, input logic ef,
                              input int lat, input int err);
    vec_t v;
    v.a = a; v.b = b; v.ctl = ctl; v.sum = sum; v.carry = carry; v.bad = bad;
    v.hold = hold; v.exp_sum = es; v.exp_carry = ec; v.exp_fail = ef;
    v.exp_lat = lat; v.exp_err = err;
    return v;
  endfunction

  localparam int S = int'(SETTLE);

  vec_t tbl[9];
  vec_t rv;
  int   err_model;
  int   first_good;
  int   nbad;
  logic seen_valid;

  initial begin
    // Absolute expectations, starting from a fresh reset (err_cnt saturates at 15)
    tbl[0] = mk(3'd3, 3'd2, 3'b001, 3'd5, 1'b0, 3'b000, 0, 3'd5, 1'b0, 1'b0, 1*S, 0);
    tbl[1] = mk(3'd3, 3'd2, 3'b001, 3'd5, 1'b0, 3'b001, 0, 3'd5, 1'b0, 1'b0, 2*S, 1);
    tbl[2] = mk(3'd1, 3'd1, 3'b010, 3'd0, 1'b1, 3'b111, 0, 3'd0, 1'b0, 1'b1, 3*S, 4);
    tbl[3] = mk(3'd7, 3'd7, 3'b100, 3'd6, 1'b1, 3'b011, 5, 3'd6, 1'b1, 1'b0, 3*S, 6);
    tbl[4] = mk(3'd0, 3'd5, 3'b001, 3'd5, 1'b0, 3'b010, 1, 3'd5, 1'b0, 1'b0, 1*S, 6);
    tbl[5] = mk(3'd2, 3'd6, 3'b010, 3'd4, 1'b1, 3'b111, 0, 3'd0, 1'b0, 1'b1, 3*S, 9);
    tbl[6] = mk(3'd4, 3'd1, 3'b100, 3'd3, 1'b0, 3'b111, 2, 3'd0, 1'b0, 1'b1, 3*S, 12);
    tbl[7] = mk(3'd5, 3'd3, 3'b001, 3'd0, 1'b1, 3'b111, 0, 3'd0, 1'b0, 1'b1, 3*S, 15);
    tbl[8] = mk(3'd6, 3'd2, 3'b010, 3'd7, 1'b1, 3'b001, 0, 3'd7, 1'b1, 1'b0, 2*S, 15);

    #12;
    chk("reset in_ready", int'(in_ready), 1);
    chk("reset outputs", int'({out_valid, out_sum, out_carry, out_fail, alu_a, alu_b, alu_c, alu_par}), 0);
    chk("reset err_cnt", int'(err_cnt), 0);
    @(posedge clk); #3; rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) run_txn($sformatf("vec%0d", i), tbl[i]);

`ifdef FT_ALU_INPUT_CHECK_EN
    run_txn("ctl_not_onehot", mk(3'd3, 3'd2, 3'b011, 3'd5, 1'b0, 3'b000, 0, 3'd0, 1'b0, 1'b1, 1, 15));
`endif

    // Reset during a retry window discards the transaction
    in_a = 3'd1; in_b = 3'd2; in_ctl = 3'b001; in_par = odd_par(3'd1, 3'd2); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    drive_alu(1'b1, 1, 3'd3, 1'b0);
    repeat (S + 1) @(posedge clk);
    #2; rst_n = 1'b0; #1;
    chk("midreset outputs", int'({out_valid, out_sum, out_carry, out_fail, alu_a, alu_b, alu_c, alu_par}), 0);
    chk("midreset err_cnt", int'(err_cnt), 0);
    chk("midreset in_ready", int'(in_ready), 1);
    @(posedge clk); #3; rst_n = 1'b1;
    drive_alu(1'b0, 0, 3'd3, 1'b0);
    seen_valid = 1'b0;
    repeat (3 * S + 4) begin
      @(posedge clk); #1;
      if (out_valid) seen_valid = 1'b1;
    end
    chk("midreset no_response", int'(seen_valid), 0);

    // Random transactions against the retry-rule model
    err_model = 0;
    for (int r = 0; r < 40; r++) begin
      rv.a = 3'($urandom); rv.b = 3'($urandom);
      rv.ctl = 3'(3'b001 << $urandom_range(0, 2));
      rv.sum = 3'($urandom); rv.carry = 1'($urandom);
      rv.bad = 3'($urandom); rv.hold = $urandom_range(0, 3);
      first_good = -1;
      for (int k = 0; k <= int'(MAX_RETRY); k++)
        if (!rv.bad[k]) begin first_good = k; break; end
      nbad = (first_good < 0) ? int'(MAX_RETRY) + 1 : first_good;
      err_model = (err_model + nbad > CNT_MAX) ? CNT_MAX : err_model + nbad;
      rv.exp_fail  = (first_good < 0);
      rv.exp_sum   = rv.exp_fail ? 3'd0 : rv.sum;
      rv.exp_carry = rv.exp_fail ? 1'b0 : rv.carry;
      rv.exp_lat   = S * (nbad + ((first_good < 0) ? 0 : 1));
      rv.exp_err   = err_model;
      run_txn($sformatf("rnd%0d", r), rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
